// File: rtl/stft_pkg.sv
// Shared constants, FSM encoding and a width helper for the STFT framer.
package stft_pkg;

   localparam int WL_DEF = 8;
   localparam int N_DEF  = 8;
   localparam int H_DEF  = 4;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      WAIT = 2'd1,
      EMIT = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module frame_ram
   import stft_pkg::*;
#(
   parameter int WL = WL_DEF,
   parameter int AW = clog2(2 * N_DEF)
) (
   input  logic          iCLK,
   input  logic          iWE,
   input  logic [AW-1:0] iWADDR,
   input  logic [WL-1:0] iWDATA,
   input  logic          iRE,
   input  logic [AW-1:0] iRADDR,
   output logic [WL-1:0] oRDATA
);

   logic [WL-1:0] mem [2**AW];

   // NOTE: the array and read register carry no reset so they map onto block RAM;
   // only the control state around them is reset.
   always_ff @(posedge iCLK) begin
      if (iWE) mem[iWADDR] <= iWDATA;
      if (iRE) oRDATA <= mem[iRADDR];
   end

endmodule

// File: rtl/stft_frame_gen.sv
// Streaming STFT framer: buffers samples in a 2N circular RAM and emits an
// N-sample frame (oldest first) after the first fill and every H samples after.
module stft_frame_gen
   import stft_pkg::*;
#(
   parameter  int WL = WL_DEF,
   parameter  int N  = N_DEF,
   parameter  int H  = H_DEF,
   localparam int AW = clog2(2 * N)
) (
   input  logic          iCLK,
   input  logic          iRSTn,
   input  logic          iCLR,
   input  logic          iEN,
   input  logic [WL-1:0] iDATA,
   output logic          oVALID,
   output logic [WL-1:0] oDATA,
   output logic          oSOF,
   output logic          oEOF,
   output logic          oOVF
);

   localparam int CW = clog2(N) + 1;

   state_t        state, nextState;
   logic [AW-1:0] wrPtr, startAddr, rdAddr;
   logic [CW-1:0] fillCnt, hopCnt, rdCnt;
   logic          full, trigger, lastRead, rdEn;
   logic          s1Valid, s1Sof, s1Eof;
   logic [WL-1:0] ramData;

   assign full     = (fillCnt == CW'(N));
   assign trigger  = iEN && (full ? (hopCnt == CW'(H - 1)) : (fillCnt == CW'(N - 1)));
   assign lastRead = (rdCnt == CW'(N - 1));
   assign rdEn     = (state == EMIT);
   assign rdAddr   = startAddr + AW'(rdCnt);

   frame_ram #(.WL(WL), .AW(AW)) uRam (
      .iCLK   (iCLK),
      .iWE    (iEN && !iCLR),
      .iWADDR (wrPtr),
      .iWDATA (iDATA),
      .iRE    (rdEn),
      .iRADDR (rdAddr),
      .oRDATA (ramData)
   );

   // NOTE: nextState gets its default before the case so no path leaves it unassigned.
   always_comb begin
      nextState = state;
      case (state)
         FILL, WAIT: if (trigger)  nextState = EMIT;
         EMIT:       if (lastRead) nextState = WAIT;
         default:                  nextState = FILL;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state     <= FILL;
         wrPtr     <= '0;
         startAddr <= '0;
         fillCnt   <= '0;
         hopCnt    <= '0;
         rdCnt     <= '0;
         s1Valid   <= 1'b0;
         s1Sof     <= 1'b0;
         s1Eof     <= 1'b0;
         oVALID    <= 1'b0;
         oDATA     <= '0;
         oSOF      <= 1'b0;
         oEOF      <= 1'b0;
         oOVF      <= 1'b0;
      end else if (iCLR) begin
         state     <= FILL;
         wrPtr     <= '0;
         startAddr <= '0;
         fillCnt   <= '0;
         hopCnt    <= '0;
         rdCnt     <= '0;
         s1Valid   <= 1'b0;
         s1Sof     <= 1'b0;
         s1Eof     <= 1'b0;
         oVALID    <= 1'b0;
         oDATA     <= '0;
         oSOF      <= 1'b0;
         oEOF      <= 1'b0;
         oOVF      <= 1'b0;
      end else begin
         state <= nextState;
         if (iEN) begin
            wrPtr <= wrPtr + AW'(1);
            if (!full) fillCnt <= fillCnt + CW'(1);
            else       hopCnt  <= (hopCnt == CW'(H - 1)) ? '0 : hopCnt + CW'(1);
         end
         // Oldest sample of the new frame sits N-1 slots behind the word written now.
         if (trigger && state != EMIT) startAddr <= wrPtr + AW'(1) - AW'(N);
         if (trigger && state == EMIT) oOVF <= 1'b1;
         rdCnt <= (rdEn && !lastRead) ? rdCnt + CW'(1) : '0;

         s1Valid <= rdEn;
         s1Sof   <= rdEn && (rdCnt == '0);
         s1Eof   <= rdEn && lastRead;
         oVALID  <= s1Valid;
         oSOF    <= s1Sof;
         oEOF    <= s1Eof;
         if (s1Valid) oDATA <= ramData;
      end
   end

endmodule

// File: tb/tb_stft_frame_gen.sv
// Directed bench for stft_frame_gen: fill, hop, overflow, clear priority, async reset.
module tb_stft_frame_gen;

   localparam int WL = 8;
   localparam int N  = 8;
   localparam int H  = 4;

   logic          iCLK = 1'b0;
   logic          iRSTn;
   logic          iCLR;
   logic          iEN;
   logic [WL-1:0] iDATA;
   logic          oVALID;
   logic [WL-1:0] oDATA;
   logic          oSOF;
   logic          oEOF;
   logic          oOVF;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [WL-1:0] d;
      logic          sof;
      logic          eof;
      int            c;
   } smp_t;

   smp_t capQ[$];

   stft_frame_gen #(.WL(WL), .N(N), .H(H)) dut (
      .iCLK   (iCLK),
      .iRSTn  (iRSTn),
      .iCLR   (iCLR),
      .iEN    (iEN),
      .iDATA  (iDATA),
      .oVALID (oVALID),
      .oDATA  (oDATA),
      .oSOF   (oSOF),
      .oEOF   (oEOF),
      .oOVF   (oOVF)
   );

   always #5 iCLK = ~iCLK;

   always @(posedge iCLK) cyc <= cyc + 1;

   // Record every valid output word with the index of the edge that produced it.
   always @(posedge iCLK) begin
      #2;
      if (oVALID === 1'b1) capQ.push_back('{d: oDATA, sof: oSOF, eof: oEOF, c: cyc});
   end

   // Drive one strobe at the current negedge; edgeNo is the rising edge that writes it.
   task automatic putSample(input logic [WL-1:0] v, input int gap, output int edgeNo);
      iEN    = 1'b1;
      iDATA  = v;
      edgeNo = cyc + 1;
      @(negedge iCLK);
      iEN = 1'b0;
      repeat (gap - 1) @(negedge iCLK);
   endtask

   task automatic waitCap(input int n, output bit ok);
      for (int i = 0; i < 60; i++) begin
         if (capQ.size() >= n) break;
         @(negedge iCLK);
      end
      ok = (capQ.size() >= n);
   endtask

   task automatic doReset();
      iRSTn = 1'b0;
      iCLR  = 1'b0;
      iEN   = 1'b0;
      iDATA = '0;
      repeat (2) @(negedge iCLK);
      iRSTn = 1'b1;
      capQ.delete();
   endtask

   task automatic test_reset();
      iRSTn = 1'b0;
      iCLR  = 1'b0;
      iEN   = 1'b0;
      iDATA = '0;
      repeat (3) @(negedge iCLK);
      checks++;
      if ({oVALID, oSOF, oEOF, oOVF, oDATA} !== 12'h0) begin
         errors++;
         $display("FAIL reset_hold: outputs=%h expected 000", {oVALID, oSOF, oEOF, oOVF, oDATA});
      end
      iRSTn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge iCLK);
         checks++;
         if ({oVALID, oSOF, oEOF, oOVF, oDATA} !== 12'h0) begin
            errors++;
            $display("FAIL reset_idle[%0d]: outputs=%h expected 000", i, {oVALID, oSOF, oEOF, oOVF, oDATA});
         end
      end
   endtask

   task automatic test_first_frame();
      int trig;
      bit ok;
      capQ.delete();
      for (int v = 1; v <= 7; v++) putSample(WL'(v), 3, trig);
      checks++;
      if (capQ.size() !== 0) begin
         errors++;
         $display("FAIL early_frame: words=%0d expected 0", capQ.size());
      end
      putSample(8'd8, 3, trig);
      waitCap(N, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL first_frame_timeout: words=%0d expected %0d", capQ.size(), N);
      end
      if (ok) for (int k = 0; k < N; k++) begin
         checks++;
         if (capQ[k].d !== WL'(k + 1) || capQ[k].sof !== (k == 0) ||
             capQ[k].eof !== (k == N - 1) || capQ[k].c !== trig + 2 + k) begin
            errors++;
            $display("FAIL first_frame[%0d]: d=%0d sof=%b eof=%b edge=%0d expected d=%0d sof=%b eof=%b edge=%0d",
                     k, capQ[k].d, capQ[k].sof, capQ[k].eof, capQ[k].c, k + 1, k == 0, k == N - 1, trig + 2 + k);
         end
      end
      repeat (3) @(negedge iCLK);
      checks++;
      if (capQ.size() !== N || oVALID !== 1'b0 || oDATA !== 8'd8 || oSOF !== 1'b0 || oEOF !== 1'b0) begin
         errors++;
         $display("FAIL first_frame_end: words=%0d valid=%b data=%0d sof=%b eof=%b expected 8 0 8 0 0",
                  capQ.size(), oVALID, oDATA, oSOF, oEOF);
      end
   endtask

   task automatic test_hop();
      int trig;
      bit ok;
      for (int f = 0; f < 2; f++) begin
         capQ.delete();
         for (int v = 0; v < H; v++) putSample(WL'(9 + 4 * f + v), 3, trig);
         waitCap(N, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL hop_timeout[%0d]: words=%0d expected %0d", f, capQ.size(), N);
         end
         if (ok) for (int k = 0; k < N; k++) begin
            checks++;
            if (capQ[k].d !== WL'(5 + 4 * f + k) || capQ[k].sof !== (k == 0) ||
                capQ[k].eof !== (k == N - 1) || capQ[k].c !== trig + 2 + k) begin
               errors++;
               $display("FAIL hop%0d[%0d]: d=%0d sof=%b eof=%b edge=%0d expected d=%0d sof=%b eof=%b edge=%0d",
                        f, k, capQ[k].d, capQ[k].sof, capQ[k].eof, capQ[k].c,
                        5 + 4 * f + k, k == 0, k == N - 1, trig + 2 + k);
            end
         end
         repeat (3) @(negedge iCLK);
         checks++;
         if (capQ.size() !== N || oOVF !== 1'b0) begin
            errors++;
            $display("FAIL hop%0d_end: words=%0d ovf=%b expected %0d 0", f, capQ.size(), oOVF, N);
         end
      end
   endtask

   task automatic test_overflow();
      int trigA, trigB, dummy;
      bit ok;
      doReset();
      for (int v = 1; v <= 7; v++) putSample(WL'(v), 3, dummy);
      putSample(8'd8, 1, trigA);
      @(negedge iCLK);
      for (int v = 9; v <= 15; v++) putSample(WL'(v), 1, dummy);
      putSample(8'd16, 1, trigB);
      waitCap(2 * N, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ovf_timeout: words=%0d expected %0d", capQ.size(), 2 * N);
      end
      if (ok) for (int k = 0; k < 2 * N; k++) begin
         int expEdge;
         expEdge = (k < N) ? trigA + 2 + k : trigB + 2 + k - N;
         checks++;
         if (capQ[k].d !== WL'(k + 1) || capQ[k].sof !== (k % N == 0) ||
             capQ[k].eof !== (k % N == N - 1) || capQ[k].c !== expEdge) begin
            errors++;
            $display("FAIL ovf_frames[%0d]: d=%0d sof=%b eof=%b edge=%0d expected d=%0d sof=%b eof=%b edge=%0d",
                     k, capQ[k].d, capQ[k].sof, capQ[k].eof, capQ[k].c,
                     k + 1, k % N == 0, k % N == N - 1, expEdge);
         end
      end
      repeat (3) @(negedge iCLK);
      checks++;
      if (oOVF !== 1'b1 || capQ.size() !== 2 * N) begin
         errors++;
         $display("FAIL ovf_flag: ovf=%b words=%0d expected 1 %0d", oOVF, capQ.size(), 2 * N);
      end
   endtask

   task automatic test_clear_priority();
      int trig, dummy, n;
      bit ok;
      doReset();
      for (int v = 1; v <= 8; v++) putSample(WL'(v), 1, trig);
      waitCap(3, ok);
      iCLR  = 1'b1;
      iEN   = 1'b1;
      iDATA = 8'hAA;
      @(negedge iCLK);
      iCLR = 1'b0;
      iEN  = 1'b0;
      checks++;
      if ({oVALID, oSOF, oEOF, oOVF, oDATA} !== 12'h0 || !ok) begin
         errors++;
         $display("FAIL clear_abort: outputs=%h started=%b expected 000 1", {oVALID, oSOF, oEOF, oOVF, oDATA}, ok);
      end
      n = capQ.size();
      for (int v = 0; v < N - 1; v++) putSample(WL'(8'h21 + v), 1, dummy);
      repeat (12) @(negedge iCLK);
      checks++;
      if (capQ.size() !== n) begin
         errors++;
         $display("FAIL clear_refill: words=%0d expected %0d", capQ.size(), n);
      end
      putSample(8'h28, 1, trig);
      waitCap(n + N, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL clear_timeout: words=%0d expected %0d", capQ.size(), n + N);
      end
      if (ok) for (int k = 0; k < N; k++) begin
         checks++;
         if (capQ[n + k].d !== WL'(8'h21 + k) || capQ[n + k].sof !== (k == 0) ||
             capQ[n + k].eof !== (k == N - 1) || capQ[n + k].c !== trig + 2 + k) begin
            errors++;
            $display("FAIL clear_frame[%0d]: d=%h sof=%b eof=%b edge=%0d expected d=%h sof=%b eof=%b edge=%0d",
                     k, capQ[n + k].d, capQ[n + k].sof, capQ[n + k].eof, capQ[n + k].c,
                     8'h21 + k, k == 0, k == N - 1, trig + 2 + k);
         end
      end
   endtask

   task automatic test_async_reset();
      int trig, dummy;
      bit ok;
      doReset();
      for (int v = 0; v < 12; v++) putSample(WL'(8'h41 + v), 1, dummy);
      checks++;
      if (oVALID !== 1'b1 || oOVF !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre: valid=%b ovf=%b expected 1 1", oVALID, oOVF);
      end
      #2 iRSTn = 1'b0;
      #1;
      checks++;
      if ({oVALID, oSOF, oEOF, oOVF, oDATA} !== 12'h0) begin
         errors++;
         $display("FAIL arst_immediate: outputs=%h expected 000", {oVALID, oSOF, oEOF, oOVF, oDATA});
      end
      @(negedge iCLK);
      iRSTn = 1'b1;
      capQ.delete();
      repeat (12) @(negedge iCLK);
      checks++;
      if (capQ.size() !== 0) begin
         errors++;
         $display("FAIL arst_idle: words=%0d expected 0", capQ.size());
      end
      for (int v = 0; v < N; v++) putSample(WL'(8'h51 + v), 2, trig);
      waitCap(N, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL arst_timeout: words=%0d expected %0d", capQ.size(), N);
      end
      if (ok) for (int k = 0; k < N; k++) begin
         checks++;
         if (capQ[k].d !== WL'(8'h51 + k) || capQ[k].sof !== (k == 0) ||
             capQ[k].eof !== (k == N - 1) || capQ[k].c !== trig + 2 + k) begin
            errors++;
            $display("FAIL arst_frame[%0d]: d=%h sof=%b eof=%b edge=%0d expected d=%h sof=%b eof=%b edge=%0d",
                     k, capQ[k].d, capQ[k].sof, capQ[k].eof, capQ[k].c,
                     8'h51 + k, k == 0, k == N - 1, trig + 2 + k);
         end
      end
      checks++;
      if (oOVF !== 1'b0) begin
         errors++;
         $display("FAIL arst_ovf: ovf=%b expected 0", oOVF);
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_hop();
      test_overflow();
      test_clear_priority();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
